// File: rtl/verin_avalon_pilot_if.sv
// Avalon-MM slave port bundle for the actuator (verin) pilot.
//   address    - register index (8 registers)
//   chipselect - slave select
//   write_n    - active-low write strobe, qualified by chipselect
//   writedata  - write data
//   readdata   - registered read data (one clock of latency)
// The master modport is used by the bus fabric or a testbench; the slave modport by the pilot.
interface verin_avalon_pilot_if;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (output address, chipselect, write_n, writedata, input readdata);
   modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/verin_avalon_pilot.sv
// Actuator (verin) power-stage pilot, controlled over Avalon-MM.
// It generates the PWM, sequences direction reversal with a dead time and stops the
// motor when an angle sample reaches the end stop for the current direction.
// Ports:
//   clk, reset_n     - system clock, asynchronous active-low reset
//   bus (slave)      - Avalon-MM register port
//   angle            - unsigned angle sample from the ADC acquisition block
//   angle_valid      - one-cycle strobe qualifying angle
//   out_pwm          - PWM to the power bridge (registered)
//   out_sens         - direction to the power bridge (registered)
//   irq              - level interrupt: end-stop flag set and interrupts enabled
// Register map: 0 CTRL {irq_en,limit_en,sens_req,enable}, 1 PERIOD, 2 DUTY, 3 LIM_G,
//   4 LIM_D, 5 STATUS (write 1 to clear bits 1 and 2), 6/7 read as zero.
module verin_avalon_pilot #(
   parameter int DEAD_CYCLES = 50,
   parameter int PERIOD_RST  = 2000,
   parameter int ANGLE_W     = 12
) (
   input  logic                    clk,
   input  logic                    reset_n,
   verin_avalon_pilot_if.slave     bus,
   input  logic [ANGLE_W-1:0]      angle,
   input  logic                    angle_valid,
   output logic                    out_pwm,
   output logic                    out_sens,
   output logic                    irq
);

   localparam int DEAD_W = $clog2(DEAD_CYCLES + 1);

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_REVERSE, ST_LIMIT} state_e;

   state_e               state_q, state_d;
   logic [3:0]           ctrl_q, ctrl_d;
   logic [15:0]          period_q, period_d, duty_q, duty_d;
   logic [ANGLE_W-1:0]   lim_g_q, lim_g_d, lim_d_q, lim_d_d;
   logic                 lg_flag_q, lg_flag_d, ld_flag_q, ld_flag_d;
   logic [ANGLE_W-1:0]   last_angle_q, last_angle_d;
   logic [15:0]          cnt_q, cnt_d, period_sh_q, period_sh_d, duty_sh_q, duty_sh_d;
   logic [DEAD_W-1:0]    dead_cnt_q, dead_cnt_d;
   logic                 target_q, target_d;
   logic                 sens_q, sens_d;
   logic                 pwm_q, pwm_d;
   logic                 irq_q, irq_d;
   logic [31:0]          rdata_q, rdata_d;

   logic        wr, enable, sens_req, limit_en;
   logic        hit_g, hit_d, enter_rev, pwm_raw;
   logic [31:0] status;
   logic        unused_wd;

   assign wr        = bus.chipselect & ~bus.write_n;
   assign enable    = ctrl_q[0];
   assign sens_req  = ctrl_q[1];
   assign limit_en  = ctrl_q[2];
   assign unused_wd = ^bus.writedata[31:16];

   // NOTE: every variable gets its hold value first so no path through the block can infer a latch.
   always_comb begin
      state_d      = state_q;
      ctrl_d       = ctrl_q;
      period_d     = period_q;
      duty_d       = duty_q;
      lim_g_d      = lim_g_q;
      lim_d_d      = lim_d_q;
      lg_flag_d    = lg_flag_q;
      ld_flag_d    = ld_flag_q;
      last_angle_d = last_angle_q;
      cnt_d        = cnt_q;
      period_sh_d  = period_sh_q;
      duty_sh_d    = duty_sh_q;
      dead_cnt_d   = dead_cnt_q;
      target_d     = target_q;
      sens_d       = sens_q;
      enter_rev    = 1'b0;
      status       = '0;

      if (wr) begin
         case (bus.address)
            3'd0:    ctrl_d   = bus.writedata[3:0];
            3'd1:    period_d = bus.writedata[15:0];
            3'd2:    duty_d   = bus.writedata[15:0];
            3'd3:    lim_g_d  = bus.writedata[ANGLE_W-1:0];
            3'd4:    lim_d_d  = bus.writedata[ANGLE_W-1:0];
            3'd5: begin
               if (bus.writedata[1]) lg_flag_d = 1'b0;
               if (bus.writedata[2]) ld_flag_d = 1'b0;
            end
            default: ;
         endcase
      end

      if (angle_valid) last_angle_d = angle;

      // End stops are only watched while actually driving; the stop that matters depends on direction.
      hit_d = (state_q == ST_RUN) & angle_valid & limit_en &  sens_q & (angle >= lim_d_q);
      hit_g = (state_q == ST_RUN) & angle_valid & limit_en & ~sens_q & (angle <= lim_g_q);
      // Applied after the clear so a simultaneous set wins.
      if (hit_g) lg_flag_d = 1'b1;
      if (hit_d) ld_flag_d = 1'b1;

      case (state_q)
         ST_IDLE: begin
            if (enable) begin
               if (sens_req != sens_q) enter_rev = 1'b1;
               else                    state_d   = ST_RUN;
            end
         end
         ST_RUN: begin
            if (!enable)                 state_d   = ST_IDLE;
            else if (sens_req != sens_q) enter_rev = 1'b1;
            else if (hit_g | hit_d)      state_d   = ST_LIMIT;
         end
         ST_REVERSE: begin
            if (!enable) begin
               state_d = ST_IDLE;
            end else if (sens_req != target_q) begin
               // Software changed its mind: restart the full dead time toward the new target.
               dead_cnt_d = '0;
               target_d   = sens_req;
            end else if (dead_cnt_q == DEAD_W'(DEAD_CYCLES - 1)) begin
               sens_d  = target_q;
               state_d = ST_RUN;
            end else begin
               dead_cnt_d = dead_cnt_q + DEAD_W'(1);
            end
         end
         default: begin // ST_LIMIT: only leaving the stop is allowed
            if (!enable)                 state_d   = ST_IDLE;
            else if (sens_req != sens_q) enter_rev = 1'b1;
         end
      endcase

      if (enter_rev) begin
         state_d    = ST_REVERSE;
         dead_cnt_d = '0;
         target_d   = sens_req;
      end

      // PWM counter: shadows reload at wrap or on RUN entry, so mid-period writes wait for the next period.
      pwm_raw = (period_sh_q != 16'd0) && (cnt_q < duty_sh_q);
      if (state_d == ST_RUN && state_q != ST_RUN) begin
         cnt_d       = '0;
         period_sh_d = period_q;
         duty_sh_d   = duty_q;
      end else if (state_q == ST_RUN) begin
         if (period_sh_q == 16'd0 || cnt_q >= period_sh_q - 16'd1) begin
            cnt_d       = '0;
            period_sh_d = period_q;
            duty_sh_d   = duty_q;
         end else begin
            cnt_d = cnt_q + 16'd1;
         end
      end else begin
         cnt_d = '0;
      end
      pwm_d = (state_q == ST_RUN && state_d == ST_RUN) ? pwm_raw : 1'b0;

      irq_d = ctrl_d[3] & (lg_flag_d | ld_flag_d);

      status[0]                = (state_q == ST_RUN);
      status[1]                = lg_flag_q;
      status[2]                = ld_flag_q;
      status[3]                = sens_q;
      status[4]                = (state_q == ST_REVERSE);
      status[16 +: ANGLE_W]    = last_angle_q;

      case (bus.address)
         3'd0:    rdata_d = {28'd0, ctrl_q};
         3'd1:    rdata_d = {16'd0, period_q};
         3'd2:    rdata_d = {16'd0, duty_q};
         3'd3:    rdata_d = 32'(lim_g_q);
         3'd4:    rdata_d = 32'(lim_d_q);
         3'd5:    rdata_d = status;
         default: rdata_d = '0;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         ctrl_q       <= '0;
         period_q     <= 16'(PERIOD_RST);
         duty_q       <= '0;
         lim_g_q      <= '0;
         lim_d_q      <= '1;
         lg_flag_q    <= 1'b0;
         ld_flag_q    <= 1'b0;
         last_angle_q <= '0;
         cnt_q        <= '0;
         period_sh_q  <= '0;
         duty_sh_q    <= '0;
         dead_cnt_q   <= '0;
         target_q     <= 1'b0;
         sens_q       <= 1'b0;
         pwm_q        <= 1'b0;
         irq_q        <= 1'b0;
         rdata_q      <= '0;
      end else begin
         state_q      <= state_d;
         ctrl_q       <= ctrl_d;
         period_q     <= period_d;
         duty_q       <= duty_d;
         lim_g_q      <= lim_g_d;
         lim_d_q      <= lim_d_d;
         lg_flag_q    <= lg_flag_d;
         ld_flag_q    <= ld_flag_d;
         last_angle_q <= last_angle_d;
         cnt_q        <= cnt_d;
         period_sh_q  <= period_sh_d;
         duty_sh_q    <= duty_sh_d;
         dead_cnt_q   <= dead_cnt_d;
         target_q     <= target_d;
         sens_q       <= sens_d;
         pwm_q        <= pwm_d;
         irq_q        <= irq_d;
         rdata_q      <= rdata_d;
      end
   end

   assign bus.readdata = rdata_q;
   assign out_pwm      = pwm_q;
   assign out_sens     = sens_q;
   assign irq          = irq_q;

endmodule

// File: tb/tb_verin_avalon_pilot.sv
// Self-checking bench for verin_avalon_pilot: directed sequence with randomized
// PWM settings and end-stop values, expectations computed from the register rules.
module tb_verin_avalon_pilot;
   localparam int DEAD = 50;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [11:0] angle;
   logic        angle_valid;
   logic        out_pwm, out_sens, irq;
   int          checks = 0;
   int          failures = 0;
   logic [31:0] rd;

   verin_avalon_pilot_if bus ();

   verin_avalon_pilot #(.DEAD_CYCLES(DEAD), .PERIOD_RST(2000), .ANGLE_W(12)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .bus         (bus.slave),
      .angle       (angle),
      .angle_valid (angle_valid),
      .out_pwm     (out_pwm),
      .out_sens    (out_sens),
      .irq         (irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Outputs are sampled 1 ns after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
      bus.address    = a;
      bus.chipselect = 1'b1;
      bus.write_n    = 1'b0;
      bus.writedata  = d;
      tick();
      bus.chipselect = 1'b0;
      bus.write_n    = 1'b1;
   endtask

   task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
      bus.address = a;
      tick();
      d = bus.readdata;
   endtask

   task automatic pulse_angle(input logic [11:0] v);
      angle       = v;
      angle_valid = 1'b1;
      tick();
      angle_valid = 1'b0;
   endtask

   // Starts RUN from IDLE with direction 0, then checks out_pwm for ncyc cycles.
   // Sample k is the k-th PWM slot after RUN entry; it is high when (k mod P) < duty of its period.
   // A DUTY write issued in slot kw lands one edge later and applies to periods starting at slot >= kw+2.
   task automatic run_pwm(input int p, input int d1, input int d2, input int kw, input int ncyc);
      int s, dcur;
      logic e;
      bus_write(3'd0, 32'h0);
      bus_write(3'd1, 32'(p));
      bus_write(3'd2, 32'(d1));
      bus_write(3'd0, 32'h1);
      tick();
      for (int k = 0; k < ncyc; k++) begin
         if (k == kw) begin
            bus.address = 3'd2; bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.writedata = 32'(d2);
         end
         tick();
         bus.chipselect = 1'b0;
         bus.write_n    = 1'b1;
         if (p == 0) begin
            e = 1'b0;
         end else begin
            s    = k - (k % p);
            dcur = (kw >= 0 && s >= kw + 2) ? d2 : d1;
            e    = ((k % p) < dcur);
         end
         check($sformatf("pwm P=%0d k=%0d", p, k), 32'(out_pwm), 32'(e));
      end
   endtask

   initial begin
      int p, d1, d2, kw, t, g, a;
      logic [2:0] st;

      reset_n = 1'b0; angle = '0; angle_valid = 1'b0;
      bus.address = '0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = '0;
      repeat (3) tick();
      check("rst pwm",  32'(out_pwm),  32'h0);
      check("rst sens", 32'(out_sens), 32'h0);
      check("rst irq",  32'(irq),      32'h0);
      check("rst rdata", bus.readdata, 32'h0);
      reset_n = 1'b1;
      bus_read(3'd1, rd); check("reset PERIOD", rd, 32'h7D0);
      bus_read(3'd0, rd); check("reset CTRL",   rd, 32'h0);
      bus_read(3'd2, rd); check("reset DUTY",   rd, 32'h0);
      bus_read(3'd3, rd); check("reset LIM_G",  rd, 32'h0);
      bus_read(3'd4, rd); check("reset LIM_D",  rd, 32'hFFF);
      bus_read(3'd5, rd); check("reset STATUS", rd, 32'h0);
      bus_write(3'd7, 32'hFFFF_FFFF);
      bus_read(3'd7, rd); check("addr7 reads 0", rd, 32'h0);

      // Directed PWM: 3 of 10 high, DUTY=7 written mid-period takes effect at the next wrap.
      run_pwm(10, 3, 7, 14, 40);
      // Randomized PWM settings, including duty at or above period.
      for (int i = 0; i < 3; i++) begin
         p  = int'($urandom_range(4, 30));
         d1 = int'($urandom_range(0, p + 3));
         d2 = int'($urandom_range(0, p + 3));
         kw = p + int'($urandom_range(1, p - 3));
         run_pwm(p, d1, d2, kw, 4 * p);
      end
      run_pwm(6, 9, 9, -1, 18);   // DUTY >= PERIOD: constant high
      run_pwm(0, 5, 5, -1, 20);   // PERIOD = 0: stays low

      // Reversal: PWM low for the dead time, direction changes, PWM restarts at slot 0.
      run_pwm(8, 3, 3, -1, 16);
      bus_write(3'd0, 32'h3);
      bus.address = 3'd5;
      for (t = 1; t <= DEAD + 18; t++) begin
         tick();
         check($sformatf("rev sens t=%0d", t), 32'(out_sens), 32'(t >= DEAD + 1));
         check($sformatf("rev pwm t=%0d", t), 32'(out_pwm),
               (t <= DEAD + 1) ? 32'h0 : 32'(((t - DEAD - 2) % 8) < 3));
         st = {bus.readdata[4], bus.readdata[3], bus.readdata[0]};
         check($sformatf("rev status t=%0d", t), 32'(st),
               32'({(t >= 2 && t <= DEAD + 1), (t >= DEAD + 2), (t == 1 || t >= DEAD + 2)}));
      end

      // Right end stop at 0x800 while moving in direction 1.
      bus_write(3'd4, 32'h800);
      bus_write(3'd0, 32'hF);
      pulse_angle(12'h7FF);
      check("below LIM_D irq", 32'(irq), 32'h0);
      bus_read(3'd5, rd); check("below LIM_D status", rd & 32'h0FFF_001F, 32'h07FF_0009);
      pulse_angle(12'h800);
      check("LIM_D irq", 32'(irq), 32'h1);
      check("LIM_D pwm", 32'(out_pwm), 32'h0);
      bus_read(3'd5, rd); check("LIM_D status", rd & 32'h0FFF_001F, 32'h0800_000C);
      repeat (4) tick();
      check("LIMIT pwm held", 32'(out_pwm), 32'h0);
      bus_write(3'd5, 32'h4);
      check("W1C irq", 32'(irq), 32'h0);
      bus_read(3'd5, rd); check("W1C status", rd & 32'h1F, 32'h08);

      // Moving away from the stop: reverse to direction 0, bounded wait.
      bus_write(3'd0, 32'hD);
      t = 0;
      while (out_sens !== 1'b0 && t < DEAD + 10) begin
         tick();
         t++;
      end
      check("leave stop dead time", 32'(t), 32'(DEAD + 1));
      bus_read(3'd5, rd); check("leave stop running", rd & 32'h1F, 32'h01);

      // Left end stop at a random value; compare is inclusive.
      g = int'($urandom_range(1, 4094));
      bus_write(3'd3, 32'(g));
      pulse_angle(12'(g + 1));
      bus_read(3'd5, rd); check("above LIM_G status", rd & 32'h1F, 32'h01);
      a = int'($urandom_range(0, g));
      pulse_angle(12'(a));
      check("LIM_G irq", 32'(irq), 32'h1);
      bus_read(3'd5, rd); check("LIM_G status", rd & 32'h0FFF_001F, (32'(a) << 16) | 32'h02);
      bus_write(3'd5, 32'h2);
      check("W1C G irq", 32'(irq), 32'h0);

      // Clearing enable during REVERSE returns to IDLE at once with direction unchanged.
      bus_write(3'd0, 32'hF);
      repeat (5) tick();
      bus_write(3'd0, 32'hE);
      bus_read(3'd5, rd); check("rev before idle", rd & 32'h1F, 32'h10);
      bus_read(3'd5, rd); check("rev abort idle", rd & 32'h1F, 32'h00);
      repeat (DEAD + 2) tick();
      check("rev abort sens", 32'(out_sens), 32'h0);

      // Reset while driving: PWM drops asynchronously.
      run_pwm(5, 9, 9, -1, 6);
      reset_n = 1'b0;
      #1;
      check("async rst pwm", 32'(out_pwm), 32'h0);
      check("async rst rdata", bus.readdata, 32'h0);
      tick();
      reset_n = 1'b1;
      bus_read(3'd1, rd); check("post rst PERIOD", rd, 32'h7D0);
      repeat (3) tick();
      check("post rst pwm", 32'(out_pwm), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
